pipeline_join: RTL

- Joins N independent valid/ready input channels into a single valid/ready output channel. This is the converging counterpart of the one-to-N pipeline distribute.
- Each input lane captures one data word into its own holding register. The output presents all N words together once every lane holds a word.
- Sits where results from parallel workers must be re-combined into one transaction, for example the partial results of a fork feeding a single downstream stage.

---
 rtl/pipeline_join.sv | 46 ++++
 1 files changed

// File: rtl/pipeline_join.sv
// Joins N valid/ready input lanes into one output transaction carrying all N words.
// Each lane parks one word in its own holding slot; the join fires once every slot is full.
module pipeline_join #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic [N*W-1:0] i_data,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [N*W-1:0] o_data
);

  logic [N-1:0]   full;
  logic [N*W-1:0] hold;
  logic [N-1:0]   in_fire;
  logic           o_fire;

  assign o_valid = &full;
  assign o_data  = hold;
  assign o_fire  = o_valid && o_ready;

  // A full lane can still accept when the join drains it in the same cycle.
  assign i_ready = ~full | {N{o_fire}};
  assign in_fire = i_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      hold <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (in_fire[k]) begin
          hold[k*W +: W] <= i_data[k*W +: W];
          full[k]        <= 1'b1;
        end else if (o_fire) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

endmodule
